// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - Shared types and constants for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } arb_owner_t;

    // Returned to the owning port when the memory never acknowledges.
    localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_fbuf.sv
// rtl/mem_arb_fbuf.sv - One-entry fetch buffer: word tag, data, valid, hit compare, write-invalidate.
module mem_arb_fbuf
    import mem_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] i_lookup_tag,
    input  logic        i_fill,
    input  logic [29:0] i_fill_tag,
    input  logic [31:0] i_fill_data,
    input  logic        i_inv,
    input  logic [29:0] i_inv_tag,
    output logic        o_hit,
    output logic [31:0] o_data
);

    logic        r_valid;
    logic [29:0] r_tag;
    logic [31:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_data  <= i_fill_data;
        end else if (i_inv && (i_inv_tag == r_tag)) begin
            r_valid <= 1'b0;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Arbitrates one single-port memory between fetch and data ports, data first.
// Optional one-entry fetch buffer enabled by defining MEM_ARB_FBUF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    arb_owner_t       r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             r_m_we;
    logic [31:0]      r_m_addr;
    logic [31:0]      r_m_wdata;
    logic [31:0]      r_if_rdata;
    logic [31:0]      r_d_rdata;
    logic             r_if_done;
    logic             r_d_done;
    logic             r_err;

    logic             w_pend_d;
    logic             w_pend_i;
    logic             w_stall;
    logic             w_issue_d;
    logic             w_issue_i;
    logic             w_hit_done;
    logic             w_ack_done;
    logic             w_tmo;
    logic             w_fb_hit;
    logic [31:0]      w_fb_data;
    logic [31:0]      w_fin_data;

    assign w_pend_d = d_req && !r_d_done;
    assign w_pend_i = if_req && !r_if_done;
    assign w_stall  = w_pend_d || w_pend_i;

`ifdef MEM_ARB_FBUF_EN
    mem_arb_fbuf u_fbuf (
        .clk          (clk),
        .rst          (rst),
        .i_lookup_tag (if_addr[31:2]),
        .i_fill       (w_ack_done && (r_owner == OWN_I)),
        .i_fill_tag   (r_m_addr[31:2]),
        .i_fill_data  (m_rdata),
        .i_inv        (w_issue_d && d_we),
        .i_inv_tag    (d_addr[31:2]),
        .o_hit        (w_fb_hit),
        .o_data       (w_fb_data)
    );
`else
    assign w_fb_hit  = 1'b0;
    assign w_fb_data = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_d   = 1'b0;
        w_issue_i   = 1'b0;
        w_hit_done  = 1'b0;
        w_ack_done  = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_d) begin
                    w_issue_d   = 1'b1;
                    w_state_nxt = WAIT;
                end else if (w_pend_i && w_fb_hit) begin
                    w_hit_done  = 1'b1;
                end else if (w_pend_i) begin
                    w_issue_i   = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (m_ack) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_fin_data = w_ack_done ? m_rdata : ARB_ERR_DATA;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= OWN_D;
            r_cnt      <= '0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_done  <= 1'b0;
            r_d_done   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_issue_d) begin
                r_owner   <= OWN_D;
                r_m_we    <= d_we;
                r_m_addr  <= d_addr;
                r_m_wdata <= d_wdata;
            end
            if (w_issue_i) begin
                r_owner  <= OWN_I;
                r_m_we   <= 1'b0;
                r_m_addr <= if_addr;
            end

            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if (!m_ack) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Clears first so a completion in the same edge wins.
            if (!w_stall || !d_req) begin
                r_d_done <= 1'b0;
            end
            if (!w_stall || !if_req) begin
                r_if_done <= 1'b0;
            end

            if (w_ack_done || w_tmo) begin
                if (r_owner == OWN_D) begin
                    if (w_tmo || !r_m_we) begin
                        r_d_rdata <= w_fin_data;
                    end
                    r_d_done <= 1'b1;
                end else begin
                    r_if_rdata <= w_fin_data;
                    r_if_done  <= 1'b1;
                end
            end
            if (w_hit_done) begin
                r_if_rdata <= w_fb_data;
                r_if_done  <= 1'b1;
            end

            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign stall    = w_stall;
    assign m_req    = (r_state == WAIT);
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign if_rdata = r_if_rdata;
    assign if_done  = r_if_done;
    assign d_rdata  = r_d_rdata;
    assign d_done   = r_d_done;
    assign err      = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Directed self-checking bench for mem_arbiter (covers MEM_ARB_FBUF_EN when defined).
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        stall;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ack   = 1'b0;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int w_cnt   = 0;
    int n_iss   = 0;
    int n0;
    logic [4:0] exp_stall;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .stall    (stall),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ack    (m_ack),
        .err      (err)
    );

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a[31:2] == 30'h10) return 32'h2002_0005;
        if (a[31:2] == 30'h20) return 32'h0000_1234;
        return {a[15:0], 16'hA5A5};
    endfunction

    // Memory model: acks on the lat-th WAIT cycle; lat = 0 never acks.
    always @(negedge clk) begin
        if (m_req) begin
            w_cnt   = w_cnt + 1;
            if (w_cnt == 1) n_iss = n_iss + 1;
            m_ack   = (lat != 0) && (w_cnt == lat);
            m_rdata = rd_val(m_addr);
        end else begin
            w_cnt = 0;
            m_ack = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        samp();
        check("rst_m_req", m_req, 0);
        check("rst_stall", stall, 0);
        check("rst_err", err, 0);
        check("rst_done", {if_done, d_done}, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_d_rdata", d_rdata, 0);
        step(); rst = 1'b1;
        step();

        // Fetch only, zero-wait memory
        lat = 1; if_req = 1'b1; if_addr = 32'h40;
        samp();
        check("f_c0_stall", stall, 1);
        check("f_c0_m_req", m_req, 0);
        step(); samp();
        check("f_c1_m_req", m_req, 1);
        check("f_c1_m_addr", m_addr, 32'h40);
        check("f_c1_stall", stall, 1);
        step(); samp();
        check("f_c2_done", if_done, 1);
        check("f_c2_rdata", if_rdata, 32'h2002_0005);
        check("f_c2_stall", stall, 0);
        step(); if_req = 1'b0;
        step();

        // Both ports pending
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; if_req = 1'b1; if_addr = 32'h44;
        exp_stall = 5'b01111;
        for (int c = 0; c < 5; c++) begin
            samp();
            check($sformatf("both_c%0d_stall", c), stall, exp_stall[c]);
            if (c == 1) begin
                check("both_m_addr1", m_addr, 32'h80);
                check("both_m_we1", m_we, 0);
            end
            if (c == 2) check("both_c2_done", {d_done, if_done}, 2'b10);
            if (c == 3) check("both_m_addr2", m_addr, 32'h44);
            if (c == 4) begin
                check("both_c4_done", {d_done, if_done}, 2'b11);
                check("both_d_rdata", d_rdata, 32'h1234);
                check("both_if_rdata", if_rdata, 32'h0044_A5A5);
            end
            step();
        end
        d_req = 1'b0; if_req = 1'b0;
        step();

        // Store, 3-cycle memory
        lat = 3; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hAA;
        for (int c = 0; c < 5; c++) begin
            samp();
            if (c == 0) check("st_c0_m_req", m_req, 0);
            if (c >= 1 && c <= 3) begin
                check($sformatf("st_c%0d_m_req", c), m_req, 1);
                check($sformatf("st_c%0d_m_we", c), m_we, 1);
                check($sformatf("st_c%0d_m_addr", c), m_addr, 32'h100);
                check($sformatf("st_c%0d_m_wdata", c), m_wdata, 32'hAA);
                check($sformatf("st_c%0d_stall", c), stall, 1);
            end
            if (c == 4) begin
                check("st_done", d_done, 1);
                check("st_d_rdata", d_rdata, 32'h1234);
                check("st_stall", stall, 0);
            end
            step();
        end
        d_req = 1'b0; d_we = 1'b0;
        step();

        // Timeout, no ack
        lat = 0; if_req = 1'b1; if_addr = 32'h48;
        for (int c = 0; c < 6; c++) begin
            samp();
            if (c >= 1 && c <= 4) check($sformatf("to_c%0d_m_req", c), m_req, 1);
            if (c == 4) check("to_c4_err", err, 0);
            if (c == 5) begin
                check("to_err", err, 1);
                check("to_done", if_done, 1);
                check("to_rdata", if_rdata, 32'hDEAD_BEEF);
                check("to_stall", stall, 0);
                check("to_m_req", m_req, 0);
            end
            step();
        end
        if_req = 1'b0;
        step(); step(); samp();
        check("to_err_sticky", err, 1);
        check("to_idle_stall", stall, 0);
        step();

        // Asynchronous reset mid-WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        samp(); step(); samp();
        check("ar_pre_m_req", m_req, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_m_req", m_req, 0);
        check("ar_err", err, 0);
        check("ar_m_addr", m_addr, 0);
        check("ar_done", {if_done, d_done}, 0);
        check("ar_stall_req", stall, 1);
        d_req = 1'b0;
        #1 check("ar_stall_idle", stall, 0);
        step(); rst = 1'b1;
        step();

        // Fetch 0x40 twice, then store to 0x40 and fetch again
        lat = 1; if_req = 1'b1; if_addr = 32'h40;
        samp(); step(); samp(); step(); samp();
        check("fb1_done", if_done, 1);
        step(); if_req = 1'b0;
        step();
        n0 = n_iss;
        if_req = 1'b1; if_addr = 32'h40;
        samp();
        check("fb2_c0_stall", stall, 1);
        step(); samp();
`ifdef MEM_ARB_FBUF_EN
        check("fb2_hit_done", if_done, 1);
        check("fb2_hit_rdata", if_rdata, 32'h2002_0005);
        check("fb2_hit_m_req", m_req, 0);
        check("fb2_hit_stall", stall, 0);
`else
        check("fb2_m_req", m_req, 1);
`endif
        step(); if_req = 1'b0;
        step(); step();
`ifdef MEM_ARB_FBUF_EN
        check("fb2_issues", n_iss, n0);
`else
        check("fb2_issues", n_iss, n0 + 1);
`endif
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h55;
        step(); step(); step();
        d_req = 1'b0; d_we = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h40;
        samp(); step(); samp();
        check("fb3_m_req", m_req, 1);
        check("fb3_m_addr", m_addr, 32'h40);
        step(); samp();
        check("fb3_done", if_done, 1);
        check("fb3_rdata", if_rdata, 32'h2002_0005);
        step(); if_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the pipeline's instruction-fetch port and its data-access port. Data requests take priority over fetches. The block raises a pipeline-wide stall until every outstanding request is serviced. It sits between the pipelined MIPS core (fetch and memory stages, hazard unit) and a unified RAM with a req/ack handshake and variable latency.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum WAIT cycles without `m_ack` before the access is abandoned.

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch port wants the word at `if_addr`
- `if_addr`  in  32  fetch byte address; bits [1:0] are ignored
- `if_rdata`  out  32  fetched instruction; valid while `if_done`
- `if_done`  out  1  fetch for the current pipeline cycle is complete
- `d_req`  in  1  data port access request
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  32  data byte address; bits [1:0] are ignored
- `d_wdata`  in  32  store data
- `d_rdata`  out  32  load data; valid while `d_done`
- `d_done`  out  1  data access complete
- `stall`  out  1  combinational; freezes the whole pipeline
- `m_req`  out  1  memory request
- `m_we`, `m_addr[31:0]`, `m_wdata[31:0]`  out  registered memory command
- `m_rdata`  in  32  memory read data; sampled on `m_ack`
- `m_ack`  in  1  memory completion; may arrive in the same cycle as `m_req`
- `err`  out  1  sticky timeout flag

## Operation
- Per-port pending flags:
  - `pend_d = d_req & ~d_done`
  - `pend_i = if_req & ~if_done`
- `stall = pend_d | pend_i`.
- FSM states: IDLE, WAIT.
  - IDLE:
    - If `pend_d`: register `d_we`, `d_addr`, `d_wdata` into the `m_*` outputs, record owner = D, go to WAIT.
    - Else if `pend_i`: register `if_addr`, `m_we = 0`, record owner = I, go to WAIT.
    - Else stay in IDLE.
  - WAIT:
    - `m_req = 1`. All `m_*` outputs stay stable.
    - On `m_ack`: capture `m_rdata` into the owner's rdata register (writes leave `d_rdata` unchanged), set the owner's done flag, go to IDLE.
- Done flags clear at any rising edge where `stall = 0` (the pipeline advances). A done flag also clears when its port's req is low.
- Timeout:
  - A WAIT counter starts at 0 on entry and increments each cycle without `m_ack`.
  - When it reaches `TIMEOUT`: set `err`, set the owner's done flag with rdata = 32'hDEAD_BEEF, go to IDLE.
  - `err` clears only on reset.
- Simultaneous `pend_d` and `pend_i` in IDLE: D is served first, then I. Both done flags are set before `stall` drops.
- Address comparison uses bits [31:2] only.

## Timing
- Reset values (applied immediately on asynchronous assertion, including mid-WAIT): state = IDLE, `m_req` = 0, `m_we` = 0, `m_addr`/`m_wdata` = 0, both rdata = 0, both done = 0, `err` = 0, counter = 0.
- `stall` depends combinationally on reset-state registers and on the req inputs.
- Single access with zero-wait memory:
  - cycle 0: IDLE, `stall` = 1
  - cycle 1: WAIT, `m_req` = 1, `m_ack` = 1
  - cycle 2: done = 1, `stall` = 0
  - Three cycles per access.
- An N-cycle memory adds N−1 cycles.
- Both ports pending with zero-wait memory: `stall` drops at cycle 4.
- `m_req` never asserts in IDLE. The state never moves from IDLE to WAIT and back in a single cycle.

## Configuration
- Macro `MEM_ARB_FBUF_EN`.
- Defined: a one-entry fetch buffer holding a tag (addr[31:2]), data and a valid bit.
  - In IDLE, if `pend_i` and the tag matches `if_addr` and valid is set, `if_done` sets at the next edge with the buffered data. No memory access occurs, so the access takes 2 cycles.
  - Every completed fetch refills the buffer.
  - A data write whose word address matches the tag clears valid in the edge where the write is issued.
  - Data priority is unchanged.
- Undefined: every fetch goes to memory. There is no tag or data storage.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `arb_state_t` {IDLE, WAIT}
  - owner enum {OWN_D, OWN_I}
  - constant `ARB_ERR_DATA` = 32'hDEAD_BEEF
- Sub-module `mem_arb_fbuf` is the fetch buffer: tag/data/valid storage, hit compare and write-invalidate. It is instantiated only under `MEM_ARB_FBUF_EN`.

## Test plan
- Fetch only: `if_addr` = 0x40, memory acks in the same cycle with 0x2002_0005 → `m_req` high in cycle 1; `if_done` = 1 and `if_rdata` = 0x2002_0005 in cycle 2; `stall` is 1, 1, 0.
- Both ports pending: load `d_addr` = 0x80 (memory returns 0x1234) and fetch 0x44 → first `m_addr` = 0x80 with `m_we` = 0, second `m_addr` = 0x44; `stall` drops only when both done = 1; `d_rdata` = 0x1234.
- Store with a 3-cycle memory latency: `d_we` = 1, `d_wdata` = 0xAA → `m_we`/`m_addr`/`m_wdata` stable for 3 WAIT cycles; `d_rdata` unchanged.
- No ack with `TIMEOUT` = 4 → after 4 WAIT cycles `err` = 1, owner rdata = 0xDEAD_BEEF, `stall` releases; `err` stays 1 until `rst` = 0.
- `rst` driven low mid-WAIT → `m_req`, the done flags and the state clear with no clock edge.
- With `MEM_ARB_FBUF_EN` defined: fetch 0x40 twice → second fetch completes in 2 cycles with no `m_req`. Then a store to 0x40 followed by fetch 0x40 → memory is accessed again.
